// File: rtl/vga_mode_ctrl.sv
// Mode sequencer for vga_generator: owns the timing parameters, swaps modes at a
// frame boundary and holds the generator in reset while the pixel PLL relocks.
module vga_mode_ctrl #(
  parameter int TIMEOUT_W   = 22,
  parameter int LOCK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_mode,
  output logic        req_ready,
  output logic        done,
  output logic        busy,
  output logic [1:0]  cur_mode,
  input  logic        vga_vs,
  input  logic        pll_locked,
  output logic [1:0]  pll_mode,
  output logic        gen_reset_n,
  output logic [11:0] h_total,
  output logic [11:0] h_sync,
  output logic [11:0] h_start,
  output logic [11:0] h_end,
  output logic [11:0] v_total,
  output logic [11:0] v_sync,
  output logic [11:0] v_start,
  output logic [11:0] v_end,
  output logic [11:0] v_active_14,
  output logic [11:0] v_active_24,
  output logic [11:0] v_active_34
);

  // state      | meaning
  // WAIT_LOCK  | generator in reset, counting consecutive pll_locked cycles
  // RUN        | generator running, requests accepted
  // WAIT_FRAME | request latched, waiting for vsync falling edge or timeout
  // BLANK      | new mode applied, generator in reset, fixed hold time

  localparam int LCW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    RUN        = 2'd1,
    WAIT_FRAME = 2'd2,
    BLANK      = 2'd3
  } state_t;

  typedef struct packed {
    logic [11:0] h_total;
    logic [11:0] h_sync;
    logic [11:0] h_start;
    logic [11:0] h_end;
    logic [11:0] v_total;
    logic [11:0] v_sync;
    logic [11:0] v_start;
    logic [11:0] v_end;
  } timing_t;

  function automatic timing_t mode_timing(input logic [1:0] m);
    timing_t t;
    case (m)
      2'd0:    t = '{12'd799,  12'd95,  12'd141, 12'd781,  12'd524,  12'd1, 12'd34, 12'd514};
      2'd1:    t = '{12'd857,  12'd61,  12'd119, 12'd839,  12'd524,  12'd5, 12'd35, 12'd515};
      2'd2:    t = '{12'd1343, 12'd135, 12'd293, 12'd1317, 12'd805,  12'd5, 12'd34, 12'd802};
      default: t = '{12'd1687, 12'd111, 12'd357, 12'd1637, 12'd1065, 12'd2, 12'd40, 12'd1064};
    endcase
    return t;
  endfunction

  function automatic logic [35:0] quarter_marks(input timing_t t);
    logic [11:0] q;
    q = (t.v_end - t.v_start) >> 2;
    return {t.v_start + q, t.v_start + (q << 1), t.v_start + q + (q << 1)};
  endfunction

  state_t               state;
  logic [1:0]           pending;
  logic                 chg_pending;
  logic [LCW-1:0]       lock_cnt;
  logic [LCW-1:0]       hold_cnt;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 vs_s;
  logic                 vs_d;
  logic                 vs_fall;

  // vs_s is the sampled input, vs_d its one-cycle copy; the edge is acted on one cycle after it is first seen
  assign vs_fall = vs_d & ~vs_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_LOCK;
      pending     <= 2'd0;
      chg_pending <= 1'b0;
      lock_cnt    <= '0;
      hold_cnt    <= '0;
      tmo_cnt     <= '0;
      vs_s        <= 1'b1;
      vs_d        <= 1'b1;
      cur_mode    <= 2'd0;
      pll_mode    <= 2'd0;
      gen_reset_n <= 1'b0;
      req_ready   <= 1'b0;
      busy        <= 1'b1;
      done        <= 1'b0;
      {h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end} <= mode_timing(2'd0);
      {v_active_14, v_active_24, v_active_34} <= quarter_marks(mode_timing(2'd0));
    end else begin
      vs_s <= vga_vs;
      vs_d <= vs_s;
      done <= 1'b0;
      case (state)
        WAIT_LOCK: begin
          if (!pll_locked) begin
            lock_cnt <= '0;
          end else if (lock_cnt == LOCK_LAST) begin
            state       <= RUN;
            lock_cnt    <= '0;
            gen_reset_n <= 1'b1;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= chg_pending;
            chg_pending <= 1'b0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        RUN: begin
          if (req_valid && req_mode != cur_mode) begin
            // a mode change relocks anyway, so it wins over a simultaneous lock loss
            state       <= WAIT_FRAME;
            pending     <= req_mode;
            chg_pending <= 1'b1;
            tmo_cnt     <= '0;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
          end else begin
            if (req_valid) done <= 1'b1;
            if (!pll_locked) begin
              state       <= WAIT_LOCK;
              lock_cnt    <= '0;
              gen_reset_n <= 1'b0;
              req_ready   <= 1'b0;
              busy        <= 1'b1;
            end
          end
        end
        WAIT_FRAME: begin
          if (vs_fall || (&tmo_cnt)) begin
            state       <= BLANK;
            hold_cnt    <= '0;
            gen_reset_n <= 1'b0;
            cur_mode    <= pending;
            pll_mode    <= pending;
            {h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end} <= mode_timing(pending);
            {v_active_14, v_active_24, v_active_34} <= quarter_marks(mode_timing(pending));
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        BLANK: begin
          if (hold_cnt == LOCK_LAST) begin
            state    <= WAIT_LOCK;
            lock_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end

endmodule
